// File: rtl/grid_pkg.sv
// Shared types and constants for the cell-grid upscaler (grid_bank_pair, grid_upscale).
package grid_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;
    localparam int CELL_IDX_W = $clog2(GRID_W_DEF * GRID_H_DEF);

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    typedef logic [CELL_IDX_W-1:0] cell_idx_t;

    typedef struct packed {
        logic [4:0] h;
        logic [4:0] v;
    } cell_coord_t;

    // Row-major flat index of a cell.
    function automatic cell_idx_t cell_index(input cell_coord_t c, input int grid_w);
        return cell_idx_t'(c.v) * cell_idx_t'(grid_w) + cell_idx_t'(c.h);
    endfunction

endpackage

// File: rtl/grid_bank_pair.sv
// Double-buffered 1-bit cell grid: write decode into the write bank, frame-aligned bank
// swap after the last cell arrives, and a registered read port on the read bank.
module grid_bank_pair
    import grid_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  cell_coord_t wr_coord,
    input  logic        wr_pixel,
    input  logic        frame_start,
    input  cell_idx_t   rd_idx,
    output logic        rd_bit
);

    localparam int CELLS = GRID_W * GRID_H;

    logic [CELLS-1:0] bank0_reg;
    logic [CELLS-1:0] bank1_reg;
    logic             wr_bank_reg;
    logic             swap_pending_reg;

    logic      wr_ok;
    logic      wr_last;
    logic      swap;
    cell_idx_t wr_idx;

    assign wr_ok   = wr_valid
                     && ({1'b0, wr_coord.h} < 6'(GRID_W))
                     && ({1'b0, wr_coord.v} < 6'(GRID_H));
    assign wr_last = wr_ok
                     && (wr_coord.h == 5'(GRID_W - 1))
                     && (wr_coord.v == 5'(GRID_H - 1));
    assign swap    = swap_pending_reg && frame_start;
    assign wr_idx  = cell_index(wr_coord, GRID_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank0_reg        <= '0;
            bank1_reg        <= '0;
            wr_bank_reg      <= 1'b0;
            swap_pending_reg <= 1'b0;
            rd_bit           <= 1'b0;
        end else begin
            // A write on the swap cycle still targets the bank being handed to the display.
            if (wr_ok) begin
                if (wr_bank_reg) begin
                    bank1_reg[wr_idx] <= wr_pixel;
                end else begin
                    bank0_reg[wr_idx] <= wr_pixel;
                end
            end

            if (swap) begin
                wr_bank_reg      <= ~wr_bank_reg;
                swap_pending_reg <= 1'b0;
            end else if (wr_last) begin
                swap_pending_reg <= 1'b1;
            end

            rd_bit <= wr_bank_reg ? bank0_reg[rd_idx] : bank1_reg[rd_idx];
        end
    end

endmodule

// File: rtl/grid_upscale.sv
// Replays the double-buffered cell grid onto the raster as SCALE x SCALE blocks at (X0,Y0).
// Optional macro GRID_UPSCALE_OVERLAY_EN draws cell borders inside the window.
module grid_upscale
    import grid_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int SCALE  = 10,
    parameter int X0     = 0,
    parameter int Y0     = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_valid_in,
    input  logic [4:0]  wr_hcount_in,
    input  logic [4:0]  wr_vcount_in,
    input  logic        wr_pixel_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    output logic        pixel_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        in_window_out,
    output logic        data_valid_out
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W = $clog2(GRID_W + 1);
    localparam int ROW_W = $clog2(GRID_H + 1);

    localparam logic [10:0]      H_LO     = 11'(X0);
    localparam logic [10:0]      H_SPAN   = 11'(GRID_W * SCALE);
    localparam logic [9:0]       V_LO     = 10'(Y0);
    localparam logic [9:0]       V_SPAN   = 10'(GRID_H * SCALE);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(GRID_W);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(GRID_H);

    logic [SUB_W-1:0] sub_h_reg, sub_h_next;
    logic [SUB_W-1:0] sub_v_reg, sub_v_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;

    logic        win1_reg, win2_reg;
    cell_idx_t   idx1_reg;
    logic [10:0] h1_reg, h2_reg;
    logic [9:0]  v1_reg, v2_reg;
    logic        dv1_reg, dv2_reg;

    logic        in_window;
    cell_idx_t   idx_next;
    cell_coord_t wr_coord;
    logic        frame_start;
    logic        rd_bit;

    // Vertical cell tracking steps once per line, at the window's left edge.
    always_comb begin
        sub_v_next = sub_v_reg;
        row_next   = row_reg;
        if (hcount_in == H_LO) begin
            if (vcount_in == V_LO) begin
                sub_v_next = '0;
                row_next   = '0;
            end else if (sub_v_reg == SUB_LAST) begin
                sub_v_next = '0;
                if (row_reg != ROW_MAX) begin
                    row_next = row_reg + ROW_W'(1);
                end
            end else begin
                sub_v_next = sub_v_reg + SUB_W'(1);
            end
        end
    end

    always_comb begin
        sub_h_next = sub_h_reg;
        col_next   = col_reg;
        if (hcount_in == H_LO) begin
            sub_h_next = '0;
            col_next   = '0;
        end else if (data_valid_in) begin
            if (sub_h_reg == SUB_LAST) begin
                sub_h_next = '0;
                if (col_reg != COL_MAX) begin
                    col_next = col_reg + COL_W'(1);
                end
            end else begin
                sub_h_next = sub_h_reg + SUB_W'(1);
            end
        end
    end

    // Modular subtraction folds the lower bound into a single range compare.
    assign in_window = data_valid_in
                       && ((hcount_in - H_LO) < H_SPAN)
                       && ((vcount_in - V_LO) < V_SPAN);
    assign idx_next  = cell_idx_t'(row_next) * cell_idx_t'(GRID_W) + cell_idx_t'(col_next);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sub_h_reg <= '0;
            sub_v_reg <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            win1_reg  <= 1'b0;
            idx1_reg  <= '0;
            h1_reg    <= '0;
            v1_reg    <= '0;
            dv1_reg   <= 1'b0;
            win2_reg  <= 1'b0;
            h2_reg    <= '0;
            v2_reg    <= '0;
            dv2_reg   <= 1'b0;
        end else begin
            sub_h_reg <= sub_h_next;
            sub_v_reg <= sub_v_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            win1_reg  <= in_window;
            idx1_reg  <= idx_next;
            h1_reg    <= hcount_in;
            v1_reg    <= vcount_in;
            dv1_reg   <= data_valid_in;
            win2_reg  <= win1_reg;
            h2_reg    <= h1_reg;
            v2_reg    <= v1_reg;
            dv2_reg   <= dv1_reg;
        end
    end

    assign wr_coord    = '{h: wr_hcount_in, v: wr_vcount_in};
    assign frame_start = (hcount_in == '0) && (vcount_in == '0);

    grid_bank_pair #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_banks (
        .clk         (clk_in),
        .rst         (rst_in),
        .wr_valid    (wr_valid_in),
        .wr_coord    (wr_coord),
        .wr_pixel    (wr_pixel_in),
        .frame_start (frame_start),
        .rd_idx      (idx1_reg),
        .rd_bit      (rd_bit)
    );

`ifdef GRID_UPSCALE_OVERLAY_EN
    logic edge1_reg, edge2_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            edge1_reg <= 1'b0;
            edge2_reg <= 1'b0;
        end else begin
            edge1_reg <= (sub_h_next == '0) || (sub_v_next == '0);
            edge2_reg <= edge1_reg;
        end
    end

    assign pixel_out = win2_reg && (rd_bit || edge2_reg);
`else
    assign pixel_out = win2_reg && rd_bit;
`endif

    assign in_window_out  = win2_reg;
    assign hcount_out     = h2_reg;
    assign vcount_out     = v2_reg;
    assign data_valid_out = dv2_reg;

endmodule

// File: tb/tb_grid_upscale.sv
// Randomized bench for grid_upscale on a reduced raster, checked against a cell-grid model.
module tb_grid_upscale;
    import grid_pkg::*;

    localparam int GW    = 32;
    localparam int GH    = 24;
    localparam int SCALE = 2;
    localparam int X0    = 4;
    localparam int Y0    = 3;
    localparam int H_TOT = 72;
    localparam int H_ACT = 70;
    localparam int V_TOT = 54;
    localparam int V_ACT = 52;

    logic        clk_in        = 1'b0;
    logic        rst_in        = 1'b1;
    logic        wr_valid_in   = 1'b0;
    logic [4:0]  wr_hcount_in  = '0;
    logic [4:0]  wr_vcount_in  = '0;
    logic        wr_pixel_in   = 1'b0;
    logic [10:0] hcount_in     = '0;
    logic [9:0]  vcount_in     = '0;
    logic        data_valid_in = 1'b0;
    logic        pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        in_window_out;
    logic        data_valid_out;

    always #5 clk_in = ~clk_in;

    grid_upscale #(
        .GRID_W (GW),
        .GRID_H (GH),
        .SCALE  (SCALE),
        .X0     (X0),
        .Y0     (Y0)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .wr_valid_in    (wr_valid_in),
        .wr_hcount_in   (wr_hcount_in),
        .wr_vcount_in   (wr_vcount_in),
        .wr_pixel_in    (wr_pixel_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .pixel_out      (pixel_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .in_window_out  (in_window_out),
        .data_valid_out (data_valid_out)
    );

    typedef struct packed {
        cell_coord_t c;
        logic        p;
    } wr_t;

    wr_t         wq[$];
    logic [23:0] exp_q[$];
    bit          m_bank [2][GH][GW];
    int          m_wr;
    bit          m_pend;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          frame_no = 0;

    function automatic logic [23:0] outs();
        return {pixel_out, in_window_out, data_valid_out, hcount_out, vcount_out};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pix=%b win=%b dv=%b h=%0d v=%0d, expected pix=%b win=%b dv=%b h=%0d v=%0d",
                     tag, got[23], got[22], got[21], got[20:10], got[9:0],
                     exp[23], exp[22], exp[21], exp[20:10], exp[9:0]);
        end
    endtask

    task automatic model_reset();
        foreach (m_bank[b, r, c]) m_bank[b][r][c] = 1'b0;
        m_wr   = 0;
        m_pend = 1'b0;
        exp_q.delete();
        wq.delete();
    endtask

    // One raster cycle: drive, advance the model, then check the pixel from two cycles back.
    task automatic tick(input int h, input int v, input bit dv, input bit force_last, input bit last_val);
        wr_t         w;
        bit          wv;
        bit          in_rng;
        bit          win;
        bit          pix;
        logic [23:0] e;
        wv    = 1'b0;
        w.c.h = 5'($urandom);
        w.c.v = 5'($urandom);
        w.p   = 1'($urandom);
        if (force_last) begin
            wv    = 1'b1;
            w.c.h = 5'(GW - 1);
            w.c.v = 5'(GH - 1);
            w.p   = last_val;
        end else if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
            wv = 1'b1;
            w  = wq.pop_front();
        end
        wr_valid_in   = wv;
        wr_hcount_in  = w.c.h;
        wr_vcount_in  = w.c.v;
        wr_pixel_in   = w.p;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_valid_in = dv;

        in_rng = wv && (int'(w.c.h) < GW) && (int'(w.c.v) < GH);
        if (in_rng) m_bank[m_wr][int'(w.c.v)][int'(w.c.h)] = w.p;
        if (m_pend && h == 0 && v == 0) begin
            m_wr   = 1 - m_wr;
            m_pend = 1'b0;
        end else if (in_rng && int'(w.c.h) == GW - 1 && int'(w.c.v) == GH - 1) begin
            m_pend = 1'b1;
        end

        win = dv && (h >= X0) && (h < X0 + GW * SCALE) && (v >= Y0) && (v < Y0 + GH * SCALE);
        pix = 1'b0;
        if (win) begin
            pix = m_bank[1 - m_wr][(v - Y0) / SCALE][(h - X0) / SCALE];
`ifdef GRID_UPSCALE_OVERLAY_EN
            if (((h - X0) % SCALE) == 0 || ((v - Y0) % SCALE) == 0) pix = 1'b1;
`endif
        end
        exp_q.push_back({pix, win, dv, 11'(h), 10'(v)});

        @(posedge clk_in);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("px", outs(), e);
        end
    endtask

    task automatic async_reset();
        rst_in = 1'b1;
        #1;
        check("async_rst", outs(), 24'd0);
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // mode 0: random cells, 1: all ones, 2: only row 3 col 7 set
    task automatic enqueue_grid(input int mode, input bit with_last);
        wr_t w;
        for (int r = 0; r < GH; r++) begin
            for (int c = 0; c < GW; c++) begin
                if (r == GH - 1 && c == GW - 1 && !with_last) continue;
                w.c.h = 5'(c);
                w.c.v = 5'(r);
                case (mode)
                    0:       w.p = 1'($urandom);
                    1:       w.p = 1'b1;
                    default: w.p = (r == 3 && c == 7);
                endcase
                wq.push_back(w);
                if ($urandom_range(0, 15) == 0) begin
                    w.c.h = 5'($urandom);
                    w.c.v = 5'($urandom_range(GH, 31));
                    w.p   = 1'b1;
                    wq.push_back(w);
                end
            end
        end
    endtask

    task automatic run_frame(input bit drop, input int rst_h, input int rst_v, input bit force_origin);
        bit line_off;
        bit lv;
        bit stop;
        lv   = 1'($urandom);
        stop = 1'b0;
        for (int v = 0; v < V_TOT && !stop; v++) begin
            line_off = drop && ($urandom_range(0, 7) == 0);
            for (int h = 0; h < H_TOT && !stop; h++) begin
                if (h == rst_h && v == rst_v) begin
                    async_reset();
                    stop = 1'b1;
                end else begin
                    tick(h, v, (h < H_ACT) && (v < V_ACT) && !line_off,
                         force_origin && h == 0 && v == 0, lv);
                end
            end
        end
        frame_no++;
        $display("[TB] frame %0d %s: %0d checks, %0d writes left",
                 frame_no, stop ? "cut by reset" : "done", n_tests, wq.size());
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check("reset", outs(), 24'd0);
        rst_in = 1'b0;

        run_frame(1'b0, -1, -1, 1'b0);

        enqueue_grid(2, 1'b0);
        repeat (3) run_frame(1'b1, -1, -1, 1'b0);

        begin
            wr_t w;
            w.c.h = 5'(GW - 1);
            w.c.v = 5'(GH - 1);
            w.p   = 1'b0;
            wq.push_back(w);
        end
        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0);

        enqueue_grid(0, 1'b1);
        run_frame(1'b1, -1, -1, 1'b0);
        run_frame(1'b1, -1, -1, 1'b0);

        enqueue_grid(0, 1'b1);
        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b1);
        run_frame(1'b0, -1, -1, 1'b0);

        enqueue_grid(1, 1'b1);
        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0);

        enqueue_grid(0, 1'b1);
        run_frame(1'b0, 40, 30, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_upscale.md
Name: grid_upscale

Overview:
- Reader/expander for the 32x24 1-bit cell grid that the pixelate stage produces.
- Captures cell writes (5-bit h/v cell index, pixel bit, valid) into a double-buffered 768-bit grid.
- Replays the grid onto the 65 MHz XGA raster, expanding each cell to a SCALE x SCALE pixel block inside a window at (X0,Y0).
- Sits between the pixelate output and the display mux.

Parameters:
- GRID_W, 32: cells per row.
- GRID_H, 24: cell rows.
- SCALE, 10: display pixels per cell edge; window size is GRID_W*SCALE x GRID_H*SCALE.
- X0, 0: window left hcount.
- Y0, 0: window top vcount.

Ports:
- clk_in  in  1  65 MHz pixel clock
- rst_in  in  1  asynchronous, active-high reset
- wr_valid_in  in  1  cell write strobe
- wr_hcount_in  in  5  cell column
- wr_vcount_in  in  5  cell row
- wr_pixel_in  in  1  cell value
- hcount_in  in  11  display raster x
- vcount_in  in  10  display raster y
- data_valid_in  in  1  raster pixel active
- pixel_out  out  1  expanded cell value
- hcount_out  out  11  hcount_in delayed 2 cycles
- vcount_out  out  10  vcount_in delayed 2 cycles
- in_window_out  out  1  pixel lies inside the grid window
- data_valid_out  out  1  data_valid_in delayed 2 cycles

Behaviour:
- Decided: one clock (clk_in); reset rst_in is asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - Both grid banks cleared to 0.
  - Write bank = 0, read bank = 1.
  - swap_pending = 0; all counters 0.
- Write side:
  - On wr_valid_in, bit [wr_vcount_in*GRID_W + wr_hcount_in] of the write bank takes wr_pixel_in.
  - Writes with wr_hcount_in >= GRID_W or wr_vcount_in >= GRID_H are ignored.
  - A write to cell (GRID_H-1, GRID_W-1) sets swap_pending.
- Bank swap:
  - Occurs when swap_pending && hcount_in==0 && vcount_in==0; write and read banks exchange and swap_pending clears.
  - If a last-cell write coincides with the swap cycle, the write lands in the old write bank, the swap is taken, and swap_pending stays 0.
  - Further last-cell writes while pending are absorbed (pending stays 1); no intermediate frame is shown.
- Raster tracking (no dividers):
  - Row state sub_v (0..SCALE-1) and row (0..GRID_H-1) update once per line, on the cycle hcount_in==X0.
    - If vcount_in==Y0: both load 0.
    - Else: sub_v increments; at SCALE-1 it wraps to 0 and row increments.
    - row saturates at GRID_H; a row value of GRID_H means outside the window.
  - Column state sub_h and col:
    - Load 0 on the cycle hcount_in==X0.
    - Otherwise advance each cycle while data_valid_in, with the same wrap/saturate rule against GRID_W.
  - The raster is assumed contiguous within a line; this is a stated requirement on the driver.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers in_window = (hcount_in in [X0, X0+GRID_W*SCALE)) && (vcount_in in [Y0, Y0+GRID_H*SCALE)), together with the cell index row*GRID_W+col.
  - Stage 2 reads the read bank:
    - pixel_out = in_window ? bit : 0.
    - Pass-through signals are delayed to match.
- data_valid_in=0: pixel_out=0 and in_window_out=0 for that pixel slot.
- Reset asserted mid-frame: everything returns to reset values immediately; the first complete frame after reset displays all zeros until a full grid has been written and swapped.

Optional Feature:
- Macro GRID_UPSCALE_OVERLAY_EN.
- Defined: inside the window, pixels with sub_h==0 or sub_v==0 force pixel_out=1, drawing a cell grid; latency unchanged.
- Undefined: no overlay; the sub-cell border logic is absent.

Decomposition:
- Package grid_pkg holds:
  - GRID_W/GRID_H defaults;
  - CELL_IDX_W = $clog2(GRID_W*GRID_H);
  - typedef cell_idx_t;
  - typedef cell_coord_t (5-bit h, 5-bit v);
  - XGA constants H_ACTIVE=1024, V_ACTIVE=768.
- Natural sub-module: grid_bank_pair, containing the two banks, write decode, bank select, swap_pending logic, and the registered read port.
- grid_upscale keeps the raster counters, window test and pipeline.

Test Plan:
- Reset then a full raster frame with no writes -> pixel_out=0 everywhere; data_valid_out tracks data_valid_in delayed 2 cycles.
- Write cell (3,7)=1, then all cells through (23,31), then frame start -> after the swap, pixels hcount 70..79 x vcount 30..39 output 1, all others 0, latency 2.
- Same writes without writing cell (23,31) -> no swap; output stays all 0 for 3 frames.
- X0=100, Y0=50; write all cells 1 and swap -> in_window_out/pixel_out=1 exactly for hcount 100..419 x vcount 50..289.
- Last-cell write on the same cycle as hcount=0/vcount=0 with swap_pending=1 -> single swap; the following frame shows the data; swap_pending=0.
- Assert rst_in at hcount=500, vcount=400 -> outputs 0 within the same cycle (async); banks cleared; next frame all 0.
- With GRID_UPSCALE_OVERLAY_EN and an all-zero grid -> pixel_out=1 at hcount X0+10k and vcount Y0+10k inside the window, 0 elsewhere.
